// File: rtl/mmio_responder.sv
// I/O-region responder on the cpu memory bus: LED, hex display, tick counter
// and synchronized switches, decoded from mem_cmd/mem_addr when mem_addr[8]=1.
module mmio_responder #(
    parameter int TICK_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [7:0]  SW,
    output logic [15:0] read_data,
    output logic        io_hit,
    output logic [7:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    localparam logic [8:0] A_LED    = 9'h100;
    localparam logic [8:0] A_HEX    = 9'h120;
    localparam logic [8:0] A_TICK   = 9'h130;
    localparam logic [8:0] A_SW     = 9'h140;
    localparam logic [8:0] A_STATUS = 9'h141;

    logic [7:0]                  led_q;
    logic [15:0]                 hex_q;
    logic                        hex_valid;
    logic [TICK_W-1:0]           tick_q;
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]                  sw_sync;
    logic [7:0]                  sw_prev;
    logic                        sw_changed;

    logic is_rd, is_wr;

    assign is_rd   = (mem_cmd == CMD_READ)  && mem_addr[8];
    assign is_wr   = (mem_cmd == CMD_WRITE) && mem_addr[8];
    assign io_hit  = is_rd || is_wr;
    assign sw_sync = sync_q[SYNC_STAGES-1];
    assign LEDR    = led_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q      <= '0;
            hex_q      <= '0;
            hex_valid  <= 1'b0;
            tick_q     <= '0;
            sync_q     <= '0;
            sw_prev    <= '0;
            sw_changed <= 1'b0;
        end else begin
            if (is_wr && mem_addr == A_LED) led_q <= write_data[7:0];
            if (is_wr && mem_addr == A_HEX) begin
                hex_q     <= write_data;
                hex_valid <= 1'b1;
            end
            // a load replaces this cycle's increment rather than adding to it
            if (is_wr && mem_addr == A_TICK) tick_q <= TICK_W'(write_data);
            else                             tick_q <= tick_q + TICK_W'(1);

            sync_q  <= {sync_q[SYNC_STAGES-2:0], SW};
            sw_prev <= sw_sync;
            // a fresh change beats the read-side clear
            if (sw_sync != sw_prev)             sw_changed <= 1'b1;
            else if (is_rd && mem_addr == A_SW) sw_changed <= 1'b0;
        end
    end

    always_comb begin
        read_data = 16'h0000;
        if (is_rd) begin
            case (mem_addr)
                A_LED:    read_data = {8'h00, led_q};
                A_HEX:    read_data = hex_q;
                A_TICK:   read_data = 16'(tick_q);
                A_SW:     read_data = {8'h00, sw_sync};
                A_STATUS: read_data = {14'd0, hex_valid, sw_changed};
                default:  read_data = 16'h0000;
            endcase
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    assign HEX0 = hex_valid ? seg(hex_q[3:0])   : 7'b1111111;
    assign HEX1 = hex_valid ? seg(hex_q[7:4])   : 7'b1111111;
    assign HEX2 = hex_valid ? seg(hex_q[11:8])  : 7'b1111111;
    assign HEX3 = hex_valid ? seg(hex_q[15:12]) : 7'b1111111;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: directed test-plan sequences followed by
// randomized bus/switch/reset traffic, checked against a behavioural model.
module tb_mmio_responder;

    localparam int TICK_W      = 16;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  SW;
    logic [15:0] read_data;
    logic        io_hit;
    logic [7:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    mmio_responder #(.TICK_W(TICK_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .SW(SW), .read_data(read_data), .io_hit(io_hit),
        .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic        hit;
        logic [7:0]  led;
        logic [27:0] hex;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural model state
    logic [7:0]  m_led;
    logic [15:0] m_hex;
    logic        m_hv;
    int unsigned m_tick;
    logic [7:0]  m_swq[$];   // delay line: front = value the DUT sees as synchronized
    logic [7:0]  m_prev;
    logic        m_chg;

    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic void model_edge();
        logic [7:0] s;
        if (reset) begin
            m_led = 0; m_hex = 0; m_hv = 0; m_tick = 0; m_prev = 0; m_chg = 0;
            m_swq.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_swq.push_back(8'h00);
        end else begin
            s = m_swq[0];
            if (s != m_prev) m_chg = 1'b1;
            else if (mem_cmd == 2'b10 && mem_addr == 9'h140) m_chg = 1'b0;
            m_prev = s;
            m_swq.push_back(SW);
            void'(m_swq.pop_front());
            if (mem_cmd == 2'b11 && mem_addr == 9'h130) m_tick = write_data;
            else m_tick = (m_tick + 1) % (1 << TICK_W);
            if (mem_cmd == 2'b11 && mem_addr == 9'h100) m_led = write_data[7:0];
            if (mem_cmd == 2'b11 && mem_addr == 9'h120) begin
                m_hex = write_data;
                m_hv  = 1'b1;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.hit = (mem_cmd == 2'b10 || mem_cmd == 2'b11) && mem_addr[8];
        e.rd  = 16'h0000;
        if (mem_cmd == 2'b10 && mem_addr[8]) begin
            if (mem_addr == 9'h100)      e.rd = {8'h00, m_led};
            else if (mem_addr == 9'h120) e.rd = m_hex;
            else if (mem_addr == 9'h130) e.rd = m_tick[15:0];
            else if (mem_addr == 9'h140) e.rd = {8'h00, m_swq[0]};
            else if (mem_addr == 9'h141) e.rd = {14'd0, m_hv, m_chg};
        end
        e.led = m_led;
        if (m_hv) e.hex = {font[m_hex[15:12]], font[m_hex[11:8]], font[m_hex[7:4]], font[m_hex[3:0]]};
        else      e.hex = {4{7'b1111111}};
        return e;
    endfunction

    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                        input logic [7:0] sw, input logic r);
        @(posedge clk);
        model_edge();
        #1;
        mem_cmd = c; mem_addr = a; write_data = d; SW = sw; reset = r;
        sb.push_back(model_out());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("read_data", 32'(read_data), 32'(e.rd));
            chk("io_hit",    32'(io_hit),    32'(e.hit));
            chk("LEDR",      32'(LEDR),      32'(e.led));
            chk("HEX",       32'({HEX3, HEX2, HEX1, HEX0}), 32'(e.hex));
        end
    end

    initial begin
        logic [7:0] sw_v;
        logic [8:0] a;
        logic [15:0] d;
        logic [1:0] c;
        reset = 1'b1; mem_cmd = 2'b00; mem_addr = 9'h000; write_data = 16'h0000; SW = 8'h00;
        sw_v = 8'h00;

        // reset, then tick read on the 5th cycle after release
        step(2'b00, 9'h000, 16'h0, sw_v, 1'b1);
        step(2'b00, 9'h000, 16'h0, sw_v, 1'b1);
        for (int i = 0; i < 4; i++) step(2'b00, 9'h000, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h130, 16'h0, sw_v, 1'b0);
        // hex register and status
        step(2'b11, 9'h120, 16'h1234, sw_v, 1'b0);
        step(2'b10, 9'h141, 16'h0, sw_v, 1'b0);
        // LED, and a RAM-side write that must not touch it
        step(2'b11, 9'h100, 16'hABCD, sw_v, 1'b0);
        step(2'b10, 9'h100, 16'h0, sw_v, 1'b0);
        step(2'b11, 9'h0FF, 16'h0011, sw_v, 1'b0);
        step(2'b00, 9'h000, 16'h0, sw_v, 1'b0);
        // switch change, flag, read-clear, set-beats-clear
        sw_v = 8'h5A;
        for (int i = 0; i < 4; i++) step(2'b10, 9'h141, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h140, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h141, 16'h0, sw_v, 1'b0);
        sw_v = 8'hC3;
        step(2'b00, 9'h000, 16'h0, sw_v, 1'b0);
        step(2'b00, 9'h000, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h140, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h141, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h140, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h141, 16'h0, sw_v, 1'b0);
        // tick wrap and load-over-increment
        step(2'b11, 9'h130, 16'hFFFE, sw_v, 1'b0);
        step(2'b10, 9'h130, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h130, 16'h0, sw_v, 1'b0);
        step(2'b11, 9'h130, 16'h1000, sw_v, 1'b0);
        step(2'b10, 9'h130, 16'h0, sw_v, 1'b0);
        // reset mid-write, then an unmapped I/O read
        step(2'b11, 9'h120, 16'h9876, sw_v, 1'b1);
        step(2'b10, 9'h120, 16'h0, sw_v, 1'b0);
        step(2'b10, 9'h155, 16'h0, sw_v, 1'b0);
        step(2'b01, 9'h100, 16'h0, sw_v, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0: a = 9'h100;
                1: a = 9'h120;
                2, 7: a = 9'h130;
                3, 8: a = 9'h140;
                4, 9: a = 9'h141;
                5: a = {1'b1, 8'($urandom)};
                default: a = {1'b0, 8'($urandom)};
            endcase
            c = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) d = 16'hFFFC + 16'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) sw_v = 8'($urandom);
            step(c, a, d, sw_v, $urandom_range(0, 79) == 0);
        end

        @(posedge clk);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #7;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
